arbitro_bloco_operativo: RTL and testbench
==========================================

Name: arbitro_bloco_operativo

Overview:
- Round-robin arbiter/scheduler sharing one datapath (bloco_controle + operative block) among N_REQ requesters.
- Accepts one request at a time, launches the datapath with the winner's operand via the start/ready/valid handshake, and returns the result tagged to that requester.
- Sits between client logic and the controller's start/ready/valid ports.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- DATA_W, 16: operand/result width.
- TIMEOUT_CYCLES, 15: watchdog limit in WAIT; used only with ARB_TIMEOUT_EN.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req  input  N_REQ  per-requester request level; held high with x_in stable until gnt.
- x_in  input  N_REQ*DATA_W  packed operands; requester i in bits [i*DATA_W +: DATA_W].
- gnt  output  N_REQ  one-hot, one-cycle accept pulse.
- done  output  N_REQ  one-hot, one-cycle result-valid pulse.
- result_out  output  DATA_W  result for the requester flagged in done; holds until the next done.
- busy  output  1  high in every state except IDLE.
- dp_start  output  1  start to the controller.
- dp_x  output  DATA_W  registered operand to the datapath.
- dp_ready  input  1  controller idle (its state 0).
- dp_valid  input  1  controller result valid.
- dp_result  input  DATA_W  datapath result.
- error  output  1  timeout pulse; constant 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - gnt, done, dp_start, busy, error = 0.
  - dp_x = 0, result_out = 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, LAUNCH, WAIT, DONE. All outputs are registered or decoded from state only; no combinational path from req to gnt.
- IDLE:
  - If dp_ready = 1 and req != 0, pick the first i with req[i] = 1, searching from (last+1) mod N_REQ upward with wrap.
  - On that edge: dp_x <= x_in[i], idx <= i, last <= i, gnt[i] = 1 for the following cycle, go to LAUNCH.
  - If dp_ready = 0, no grant; stay in IDLE.
- LAUNCH:
  - dp_start = 1.
  - If dp_ready = 1 is sampled, go to WAIT. Otherwise hold dp_start high and stay.
  - gnt is high only in the first LAUNCH cycle.
- WAIT:
  - dp_start = 0.
  - On dp_valid = 1: result_out <= dp_result, go to DONE.
  - A dp_valid seen while in IDLE or LAUNCH is ignored.
- DONE:
  - done[idx] = 1 for exactly one cycle, then go to IDLE.
  - Earliest next grant is the cycle after DONE.
- Latency with the 8-state controller: grant edge to done pulse is 10 cycles (1 LAUNCH + 8 WAIT + 1 DONE).
- Fairness: a requester that was just served has the lowest priority next round. With all req high, grant order is 0,1,2,3,0,…
- A req dropped before gnt is legal and is simply not granted. req is ignored outside IDLE.
- Reset asserted mid-operation returns to IDLE at once and drops dp_start. A result then arriving from the datapath is discarded.
- No queueing: exactly one operation in flight.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit+ counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without dp_valid: error = 1 for one cycle, done[idx] = 1 with result_out unchanged, return to IDLE.
  - A late dp_valid arriving after that is ignored.
- Not defined: no counter; WAIT waits indefinitely; error is tied to 0.

Test Plan:
- Reset then single request: reset=0 for 3 cycles → all outputs 0. Then req=4'b0100, x_in[2]=16'h0005, datapath model valid 8 cycles after start with result 16'h0019 → gnt=4'b0100 one cycle, dp_x=5, dp_start one cycle, done=4'b0100 with result_out=16'h0019, 10 cycles after grant.
- All four requesting continuously with x=1,2,3,4 → grants in order 0,1,2,3,0; each done carries its own operand's result; never two gnt bits high.
- dp_ready held 0 for 5 cycles after grant → dp_start stays high in LAUNCH until dp_ready=1; no early done.
- Reset pulse (reset=0) during WAIT at cycle 4 → busy=0 immediately; a later dp_valid produces no done; next req=4'b0001 is granted normally.
- req[1] raised while busy with requester 3 → not granted until IDLE; then granted next, since the pointer moved past 3.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=15, dp_valid never asserted → error=1 and done[idx]=1 exactly 15 WAIT cycles in; result_out unchanged; return to IDLE.

Source files
------------

// File: rtl/arbitro_bloco_operativo.sv
// Round-robin arbiter that shares one start/ready/valid datapath among N_REQ requesters.
// Optional watchdog in WAIT enabled by defining ARB_TIMEOUT_EN.
module arbitro_bloco_operativo #(
    parameter int N_REQ          = 4,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   x_in,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic [DATA_W-1:0]         result_out,
    output logic                      busy,
    output logic                      dp_start,
    output logic [DATA_W-1:0]         dp_x,
    input  logic                      dp_ready,
    input  logic                      dp_valid,
    input  logic [DATA_W-1:0]         dp_result,
    output logic                      error
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("arbitro_bloco_operativo: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [DATA_W-1:0]   dp_x_q, dp_x_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic [DATA_W-1:0]   x_arr [N_REQ];
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic [IDX_W-1:0]    cand;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 4) ? $clog2(TIMEOUT_CYCLES + 1) : 4;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                error_q, error_d;
`endif

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            x_arr[i] = x_in[i*DATA_W +: DATA_W];
        end
    end

    // Search starts just past the last winner so it becomes lowest priority.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((32'(last_q) + 32'(k)) % N_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        idx_d    = idx_q;
        gnt_d    = '0;
        dp_x_d   = dp_x_q;
        result_d = result_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        error_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (dp_ready && pick_found) begin
                    dp_x_d  = x_arr[pick_idx];
                    idx_d   = pick_idx;
                    last_d  = pick_idx;
                    gnt_d   = ONE_HOT0 << pick_idx;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (dp_ready) begin
                    state_d = S_WAIT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_WAIT: begin
                if (dp_valid) begin
                    result_d = dp_result;
                    state_d  = S_DONE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            last_q   <= IDX_W'(N_REQ - 1);
            idx_q    <= '0;
            gnt_q    <= '0;
            dp_x_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            gnt_q    <= gnt_d;
            dp_x_q   <= dp_x_d;
            result_q <= result_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign gnt        = gnt_q;
    assign done       = (state_q == S_DONE) ? (ONE_HOT0 << idx_q) : '0;
    assign result_out = result_q;
    assign busy       = (state_q != S_IDLE);
    assign dp_start   = (state_q == S_LAUNCH);
    assign dp_x       = dp_x_q;

endmodule

// File: tb/tb_arbitro_bloco_operativo.sv
// Directed bench for arbitro_bloco_operativo with a behavioural 8-cycle datapath controller
// whose result is operand squared.
module tb_arbitro_bloco_operativo;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] x_in;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [15:0] result_out;
    logic        busy;
    logic        dp_start;
    logic [15:0] dp_x;
    logic        dp_ready;
    logic        dp_valid;
    logic [15:0] dp_result;
    logic        error;

    int          checks;
    int          errors;
    int          mdl_cnt;
    int          hold;
    logic        mute;
    logic [15:0] mdl_x;

    arbitro_bloco_operativo #(
        .N_REQ(4),
        .DATA_W(16),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req(req),
        .x_in(x_in),
        .gnt(gnt),
        .done(done),
        .result_out(result_out),
        .busy(busy),
        .dp_start(dp_start),
        .dp_x(dp_x),
        .dp_ready(dp_ready),
        .dp_valid(dp_valid),
        .dp_result(dp_result),
        .error(error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: the controller model samples start/ready before the edge, inputs move 1 ns after.
    task automatic tick();
        logic        s_start;
        logic        s_ready;
        logic [15:0] s_x;
        s_start = dp_start;
        s_ready = dp_ready;
        s_x     = dp_x;
        @(posedge clock);
        #1;
        if (s_start && s_ready) begin
            mdl_cnt = 8;
            mdl_x   = s_x;
        end else if (mdl_cnt > 0) begin
            mdl_cnt--;
        end
        if (hold > 0) hold--;
        dp_ready  = (mdl_cnt == 0) && (hold == 0);
        dp_valid  = (mdl_cnt == 1) && !mute;
        dp_result = mdl_x * mdl_x;
    endtask

    task automatic run_and_check(input string tag, input logic [3:0] exp_g,
                                 input logic [15:0] exp_x, input logic [15:0] exp_r,
                                 input logic [3:0] req_after);
        int n;
        int extra;
        n = 0;
        while (gnt == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " gnt"}, 32'(gnt), 32'(exp_g));
        chk({tag, " dp_x"}, 32'(dp_x), 32'(exp_x));
        chk({tag, " dp_start"}, 32'(dp_start), 32'd1);
        req = req_after;
        tick();
        chk({tag, " gnt_one_cycle"}, 32'(gnt), 32'd0);
        chk({tag, " dp_start_one_cycle"}, 32'(dp_start), 32'd0);
        n     = 1;
        extra = 0;
        while (done == 4'b0 && n < 30) begin
            tick();
            n++;
            if (gnt != 4'b0) extra++;
        end
        chk({tag, " latency"}, 32'(n), 32'd9);
        chk({tag, " done"}, 32'(done), 32'(exp_g));
        chk({tag, " result"}, 32'(result_out), 32'(exp_r));
        chk({tag, " no_gnt_in_flight"}, 32'(extra), 32'd0);
        tick();
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        mdl_cnt   = 0;
        hold      = 0;
        mute      = 1'b0;
        mdl_x     = '0;
        reset     = 1'b0;
        req       = '0;
        x_in      = '0;
        dp_ready  = 1'b1;
        dp_valid  = 1'b0;
        dp_result = '0;

        repeat (3) tick();
        chk("rst gnt", 32'(gnt), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst dp_start", 32'(dp_start), 32'd0);
        chk("rst dp_x", 32'(dp_x), 32'd0);
        chk("rst result", 32'(result_out), 32'd0);
        chk("rst error", 32'(error), 32'd0);

        reset          = 1'b1;
        x_in[32 +: 16] = 16'h0005;
        req            = 4'b0100;
        run_and_check("single", 4'b0100, 16'h0005, 16'h0019, 4'b0000);
        chk("single idle", 32'(busy), 32'd0);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        x_in  = {16'd4, 16'd3, 16'd2, 16'd1};
        req   = 4'b1111;
        run_and_check("rr0", 4'b0001, 16'd1, 16'd1, 4'b1111);
        run_and_check("rr1", 4'b0010, 16'd2, 16'd4, 4'b1111);
        run_and_check("rr2", 4'b0100, 16'd3, 16'd9, 4'b1111);
        run_and_check("rr3", 4'b1000, 16'd4, 16'd16, 4'b1111);
        run_and_check("rr4", 4'b0001, 16'd1, 16'd1, 4'b0000);

        x_in[16 +: 16] = 16'd7;
        req            = 4'b0010;
        n = 0;
        while (gnt == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk("stall gnt", 32'(gnt), 32'b0010);
        req      = 4'b0000;
        hold     = 5;
        dp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall dp_start_held", 32'(dp_start), 32'd1);
            chk("stall no_done", 32'(done), 32'd0);
        end
        tick();
        chk("stall dp_start_drop", 32'(dp_start), 32'd0);
        repeat (8) tick();
        chk("stall done", 32'(done), 32'b0010);
        chk("stall result", 32'(result_out), 32'h0031);
        tick();

        x_in[0 +: 16] = 16'd9;
        req           = 4'b0001;
        n = 0;
        while (gnt == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk("rstmid gnt", 32'(gnt), 32'b0001);
        req = 4'b0000;
        repeat (4) tick();
        reset = 1'b0;
        #1;
        chk("rstmid busy", 32'(busy), 32'd0);
        chk("rstmid dp_start", 32'(dp_start), 32'd0);
        tick();
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (done != 4'b0) n++;
        end
        chk("rstmid late_valid_ignored", 32'(n), 32'd0);
        req = 4'b0001;
        run_and_check("rstmid regrant", 4'b0001, 16'd9, 16'h0051, 4'b0000);

        x_in[48 +: 16] = 16'd3;
        req            = 4'b1000;
        run_and_check("ptr3", 4'b1000, 16'd3, 16'd9, 4'b1010);
        run_and_check("ptr1", 4'b0010, 16'd7, 16'h0031, 4'b0000);

`ifdef ARB_TIMEOUT_EN
        mute = 1'b1;
        req  = 4'b0001;
        n = 0;
        while (gnt == 4'b0 && n < 20) begin
            tick();
            n++;
        end
        chk("tmo gnt", 32'(gnt), 32'b0001);
        req = 4'b0000;
        tick();
        repeat (14) tick();
        chk("tmo early_done", 32'(done), 32'd0);
        chk("tmo early_error", 32'(error), 32'd0);
        tick();
        chk("tmo done", 32'(done), 32'b0001);
        chk("tmo error", 32'(error), 32'd1);
        chk("tmo result_held", 32'(result_out), 32'h0031);
        tick();
        chk("tmo error_one_cycle", 32'(error), 32'd0);
        chk("tmo idle", 32'(busy), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
